// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
//   MC_CNT_W    width of the multi-cycle length field and down-counter
//   STALL_W     stall vector width: [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb [5]=wb
//   mc_state_e  IDLE/RUN/DONE states of the multi-cycle sequencer
//   STALL_*     stall vector constants, one per requesting stage
package pipe_ctrl_pkg;

    localparam int unsigned MC_CNT_W = 6;
    localparam int unsigned STALL_W  = 6;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RUN  = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    // A stage's stall holds its own register and every register in front of it.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_mc_seq.sv
// Multi-cycle EX operation sequencer (MULT/DIV): IDLE/RUN/DONE FSM with a
// down-counter holding the remaining extra cycles.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       EX presents a multi-cycle op this cycle
//   cycles_i      extra cycles the op needs
//   cancel_i      abort the in-flight op
//   flush_i       pipeline flush, also aborts the op
//   hold_i        MEM stall; keeps the result parked in DONE
//   mc_stall_o    EX-stage stall request (combinational)
//   mc_busy_o     FSM not in IDLE (combinational)
//   mc_done_o     result valid in EX this cycle (combinational)
module pipe_ctrl_mc_seq
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [MC_CNT_W-1:0] cycles_i,
    input  logic                cancel_i,
    input  logic                flush_i,
    input  logic                hold_i,
    output logic                mc_stall_o,
    output logic                mc_busy_o,
    output logic                mc_done_o
);

    mc_state_e           state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic                abort;
    logic                accept;

    assign abort  = flush_i | cancel_i;
    assign accept = start_i & ~abort;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MC_IDLE: begin
                if (accept) begin
                    if (cycles_i == '0) begin
                        state_d = MC_DONE;
                    end else begin
                        state_d = MC_RUN;
                        cnt_d   = cycles_i;
                    end
                end
            end
            MC_RUN: begin
                if (abort) begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end else begin
                    // cnt_q is at least 1 in RUN, so this cannot wrap.
                    cnt_d = cnt_q - MC_CNT_W'(1);
                    if (cnt_q == MC_CNT_W'(1)) begin
                        state_d = MC_DONE;
                    end
                end
            end
            MC_DONE: begin
                if (abort) begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end else if (!hold_i) begin
                    state_d = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs from state and inputs.
    always_comb begin
        mc_stall_o = 1'b0;
        mc_busy_o  = 1'b0;
        mc_done_o  = 1'b0;
        unique case (state_q)
            MC_IDLE: mc_stall_o = accept;
            MC_RUN: begin
                mc_stall_o = 1'b1;
                mc_busy_o  = 1'b1;
            end
            MC_DONE: begin
                mc_busy_o = 1'b1;
                // An abort in DONE discards the result.
                mc_done_o = ~abort;
            end
            default: begin
                mc_stall_o = 1'b0;
            end
        endcase
    end

endmodule : pipe_ctrl_mc_seq

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges stage stall requests into one per-register
// stall vector, sequences multi-cycle EX ops, requests id_ex bubbles and
// turns a MEM-stage exception/redirect into a flush.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   if/id/ex/mem_stallreq_i  per-stage stall requests
//   flush_req_i      MEM-stage exception/redirect
//   mc_start_i, mc_cycles_i, mc_cancel_i   multi-cycle op control
//   stall_o          per-register hold vector
//   flush_o          clear if_id/id_ex/ex_mem this cycle
//   id_ex_bubble_o   id_ex loads a NOP
//   mc_busy_o, mc_done_o  multi-cycle status
// All outputs are combinational and forced to 0 while rst is high.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                if_stallreq_i,
    input  logic                id_stallreq_i,
    input  logic                ex_stallreq_i,
    input  logic                mem_stallreq_i,
    input  logic                flush_req_i,
    input  logic                mc_start_i,
    input  logic [MC_CNT_W-1:0] mc_cycles_i,
    input  logic                mc_cancel_i,
    output logic [STALL_W-1:0]  stall_o,
    output logic                flush_o,
    output logic                id_ex_bubble_o,
    output logic                mc_busy_o,
    output logic                mc_done_o
);

    logic mc_stall;
    logic mc_busy;
    logic mc_done;

    pipe_ctrl_mc_seq u_mc_seq (
        .clk        (clk),
        .rst        (rst),
        .start_i    (mc_start_i),
        .cycles_i   (mc_cycles_i),
        .cancel_i   (mc_cancel_i),
        .flush_i    (flush_req_i),
        .hold_i     (mem_stallreq_i),
        .mc_stall_o (mc_stall),
        .mc_busy_o  (mc_busy),
        .mc_done_o  (mc_done)
    );

    // Stall priority encoder, oldest stage wins; flush overrides everything.
    always_comb begin
        stall_o        = STALL_NONE;
        flush_o        = 1'b0;
        id_ex_bubble_o = 1'b0;
        mc_busy_o      = 1'b0;
        mc_done_o      = 1'b0;
        if (!rst) begin
            if (flush_req_i) begin
                flush_o = 1'b1;
            end else if (mem_stallreq_i) begin
                stall_o = STALL_MEM;
            end else if (ex_stallreq_i || mc_stall) begin
                stall_o = STALL_EX;
            end else if (id_stallreq_i) begin
                stall_o = STALL_ID;
            end else if (if_stallreq_i) begin
                stall_o = STALL_IF;
            end
            // ID holds while EX advances: feed a NOP into EX.
            id_ex_bubble_o = stall_o[2] & ~stall_o[3] & ~flush_o;
            mc_busy_o      = mc_busy;
            mc_done_o      = mc_done;
        end
    end

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for the stall priority logic
// plus hand-written multi-cycle sequences.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic       if_r, id_r, ex_r, mem_r, fl_r, st_r, ca_r;
    logic [5:0] cyc_r;
    logic [5:0] stall_o;
    logic       flush_o, bub_o, busy_o, done_o;

    int checks;
    int errors;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .if_stallreq_i  (if_r),
        .id_stallreq_i  (id_r),
        .ex_stallreq_i  (ex_r),
        .mem_stallreq_i (mem_r),
        .flush_req_i    (fl_r),
        .mc_start_i     (st_r),
        .mc_cycles_i    (cyc_r),
        .mc_cancel_i    (ca_r),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .id_ex_bubble_o (bub_o),
        .mc_busy_o      (busy_o),
        .mc_done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       i_if, i_id, i_ex, i_mem, i_fl, i_st, i_ca;
        logic [5:0] e_stall;
        logic       e_flush;
        logic       e_bub;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [5:0] es, input logic ef,
                           input logic eb, input logic ey, input logic ed);
        chk({name, ".stall"}, 8'(stall_o), 8'(es));
        chk({name, ".flush"}, 8'(flush_o), 8'(ef));
        chk({name, ".bubble"}, 8'(bub_o), 8'(eb));
        chk({name, ".busy"}, 8'(busy_o), 8'(ey));
        chk({name, ".done"}, 8'(done_o), 8'(ed));
    endtask

    task automatic idle_inputs();
        if_r = 0; id_r = 0; ex_r = 0; mem_r = 0; fl_r = 0; st_r = 0; ca_r = 0; cyc_r = '0;
    endtask

    // Advance to the next cycle; inputs change right after the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{0,0,0,0,0,0,0, 6'b000000, 0, 0};
        vecs[1]  = '{1,0,0,0,0,0,0, 6'b000011, 0, 0};
        vecs[2]  = '{0,1,0,0,0,0,0, 6'b000111, 0, 1};
        vecs[3]  = '{0,0,1,0,0,0,0, 6'b001111, 0, 0};
        vecs[4]  = '{0,0,0,1,0,0,0, 6'b011111, 0, 0};
        vecs[5]  = '{0,1,0,1,0,0,0, 6'b011111, 0, 0};
        vecs[6]  = '{1,1,1,1,1,0,0, 6'b000000, 1, 0};
        vecs[7]  = '{1,1,0,0,0,0,0, 6'b000111, 0, 1};
        vecs[8]  = '{0,1,1,0,0,0,0, 6'b001111, 0, 0};
        vecs[9]  = '{0,0,0,0,0,1,1, 6'b000000, 0, 0};
        vecs[10] = '{0,0,0,0,1,1,0, 6'b000000, 1, 0};
        vecs[11] = '{0,1,0,0,0,1,1, 6'b000111, 0, 1};

        // Reset with every request asserted: all outputs forced low.
        rst = 1; if_r = 1; id_r = 1; ex_r = 1; mem_r = 1; fl_r = 1; st_r = 1; ca_r = 1;
        cyc_r = 6'd3;
        tick(); #1;
        chk_all("reset0", 6'b000000, 0, 0, 0, 0);
        tick(); #1;
        chk_all("reset1", 6'b000000, 0, 0, 0, 0);
        rst = 0; idle_inputs();
        tick(); #1;
        chk_all("post_reset", 6'b000000, 0, 0, 0, 0);

        // Priority table; none of these starts an op, so the FSM stays IDLE.
        for (int i = 0; i < 12; i++) begin
            if_r = vecs[i].i_if; id_r = vecs[i].i_id; ex_r = vecs[i].i_ex;
            mem_r = vecs[i].i_mem; fl_r = vecs[i].i_fl; st_r = vecs[i].i_st;
            ca_r = vecs[i].i_ca; cyc_r = 6'd2;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush,
                    vecs[i].e_bub, 0, 0);
            tick();
        end
        idle_inputs();
        #1;
        chk("table_no_accept.busy", 8'(busy_o), 8'd0);
        tick();

        // N=3: stall T..T+3, done at T+4, idle at T+5.
        st_r = 1; cyc_r = 6'd3; #1;
        chk_all("n3_T", 6'b001111, 0, 0, 0, 0);
        tick(); idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            #1; chk_all($sformatf("n3_T%0d", k), 6'b001111, 0, 0, 1, 0);
            tick();
        end
        #1; chk_all("n3_T4", 6'b000000, 0, 0, 1, 1);
        tick(); #1; chk_all("n3_T5", 6'b000000, 0, 0, 0, 0);
        tick();

        // N=0: stall at T only, done at T+1.
        st_r = 1; cyc_r = 6'd0; #1;
        chk_all("n0_T", 6'b001111, 0, 0, 0, 0);
        tick(); idle_inputs();
        #1; chk_all("n0_T1", 6'b000000, 0, 0, 1, 1);
        tick(); #1; chk_all("n0_T2", 6'b000000, 0, 0, 0, 0);
        tick();

        // N=5 flushed at T+2: no done afterwards.
        st_r = 1; cyc_r = 6'd5; tick(); idle_inputs();
        #1; chk_all("fl_T1", 6'b001111, 0, 0, 1, 0);
        tick(); fl_r = 1;
        #1; chk_all("fl_T2", 6'b000000, 1, 0, 1, 0);
        tick(); fl_r = 0;
        for (int k = 3; k <= 8; k++) begin
            #1; chk_all($sformatf("fl_T%0d", k), 6'b000000, 0, 0, 0, 0);
            tick();
        end

        // Same with mc_cancel: EX still holds in the cancel cycle.
        st_r = 1; cyc_r = 6'd5; tick(); idle_inputs();
        tick(); ca_r = 1;
        #1; chk_all("ca_T2", 6'b001111, 0, 0, 1, 0);
        tick(); ca_r = 0;
        for (int k = 3; k <= 8; k++) begin
            #1; chk_all($sformatf("ca_T%0d", k), 6'b000000, 0, 0, 0, 0);
            tick();
        end

        // Cancel on the DONE cycle suppresses the pulse.
        st_r = 1; cyc_r = 6'd0; tick(); idle_inputs(); ca_r = 1;
        #1; chk_all("cadone_T1", 6'b000000, 0, 0, 1, 0);
        tick(); ca_r = 0;
        #1; chk_all("cadone_T2", 6'b000000, 0, 0, 0, 0);
        tick();

        // DONE held by MEM stall for two cycles.
        st_r = 1; cyc_r = 6'd1; tick(); idle_inputs();
        #1; chk_all("hold_T1", 6'b001111, 0, 0, 1, 0);
        tick(); mem_r = 1;
        #1; chk_all("hold_T2", 6'b011111, 0, 0, 1, 1);
        tick();
        #1; chk_all("hold_T3", 6'b011111, 0, 0, 1, 1);
        tick(); mem_r = 0;
        #1; chk_all("hold_T4", 6'b000000, 0, 0, 1, 1);
        tick();
        #1; chk_all("hold_T5", 6'b000000, 0, 0, 0, 0);
        tick();

        // Second start while busy is ignored; exactly one done pulse.
        begin
            int pulses;
            pulses = 0;
            st_r = 1; cyc_r = 6'd2; tick();
            cyc_r = 6'd0;
            #1; chk_all("busy_T1", 6'b001111, 0, 0, 1, 0);
            tick();
            #1; chk_all("busy_T2", 6'b001111, 0, 0, 1, 0);
            tick();
            #1; chk_all("busy_T3", 6'b000000, 0, 0, 1, 1);
            pulses += int'(done_o);
            tick(); idle_inputs();
            for (int k = 4; k <= 8; k++) begin
                #1; chk_all($sformatf("busy_T%0d", k), 6'b000000, 0, 0, 0, 0);
                pulses += int'(done_o);
                tick();
            end
            chk("busy_pulses", 8'(pulses), 8'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_ctrl
